// File: rtl/cdr_pkg.sv
// Shared CDR definitions: loop-filter state and step-direction encodings, plus the
// phase-select width used by the loop filter and the phase rotator.
package cdr_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_STEP,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_t;

  // A vote counts only when exactly one of up/dn is asserted.
  function automatic logic signed [1:0] vote_decode(input logic up, input logic dn);
    if (up && !dn) begin
      return 2'sd1;
    end else if (dn && !up) begin
      return -2'sd1;
    end
    return 2'sd0;
  endfunction

endpackage

// File: rtl/cdr_vote_acc.sv
// Saturating signed vote accumulator. acc_sum is the saturated next value so the
// caller can test it against the step threshold before choosing to load or clear.
module cdr_vote_acc #(
  parameter int ACC_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic signed [1:0]       vote,
  output logic signed [ACC_W-1:0] acc_sum
);

  localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W:0]   wide_sum;

  always_comb begin
    wide_sum = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W - 1){vote[1]}}, vote};
    if (wide_sum > ACC_MAX) begin
      acc_sum = ACC_MAX[ACC_W-1:0];
    end else if (wide_sum < ACC_MIN) begin
      acc_sum = ACC_MIN[ACC_W-1:0];
    end else begin
      acc_sum = wide_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (load) begin
      acc_reg <= acc_sum;
    end
  end

endmodule

// File: rtl/cdr_loop_filter.sv
// CDR loop filter: integrates bang-bang votes, issues single-cycle inc/dec steps to
// the phase rotator with a settling hold-off, mirrors its phase and detects dither lock.
module cdr_loop_filter
  import cdr_pkg::*;
#(
  parameter int ACC_W       = 6,
  parameter int THRESH      = 16,
  parameter int HOLDOFF     = 4,
  parameter int LOCK_DITHER = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               dn,
  output logic               inc,
  output logic               dec,
  output logic [PHASE_W-1:0] phase_sel,
  output logic               locked
);

  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int DITH_W = $clog2(LOCK_DITHER + 1);
  localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [DITH_W-1:0]   dither_cnt_reg, dither_cnt_next;
  dir_t                last_dir_reg, last_dir_next;
  logic                inc_reg, inc_next;
  logic                dec_reg, dec_next;
  logic [PHASE_W-1:0]  phase_reg, phase_next;
  logic                locked_reg, locked_next;

  logic                    acc_clr;
  logic                    acc_load;
  logic signed [1:0]       vote;
  logic signed [ACC_W-1:0] acc_sum;
  dir_t                    step_dir;

  assign vote = vote_decode(up, dn);

  cdr_vote_acc #(
    .ACC_W (ACC_W)
  ) u_vote_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .load    (acc_load),
    .vote    (vote),
    .acc_sum (acc_sum)
  );

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    dither_cnt_next = dither_cnt_reg;
    last_dir_next   = last_dir_reg;
    inc_next        = 1'b0;
    dec_next        = 1'b0;
    locked_next     = locked_reg;
    acc_clr         = 1'b0;
    acc_load        = 1'b0;
    step_dir        = DIR_NONE;
    // The rotator sees every pulse that was high, even one cut short by en=0.
    phase_next      = phase_reg + PHASE_W'(inc_reg) - PHASE_W'(dec_reg);

    if (!en) begin
      state_next      = ST_IDLE;
      acc_clr         = 1'b1;
      hold_cnt_next   = '0;
      dither_cnt_next = '0;
      locked_next     = 1'b0;
      last_dir_next   = DIR_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_TRACK;
          acc_clr    = 1'b1;
        end
        ST_TRACK: begin
          if (acc_sum >= THR_POS) begin
            step_dir = DIR_UP;
          end else if (acc_sum <= THR_NEG) begin
            step_dir = DIR_DN;
          end else begin
            acc_load = 1'b1;
          end
          if (step_dir != DIR_NONE) begin
            state_next = ST_STEP;
            acc_clr    = 1'b1;
            inc_next   = (step_dir == DIR_UP);
            dec_next   = (step_dir == DIR_DN);
            // A reversal extends the dither run; any repeat restarts it.
            if (last_dir_reg != DIR_NONE && last_dir_reg != step_dir) begin
              if (dither_cnt_reg != DITH_W'(LOCK_DITHER)) begin
                dither_cnt_next = dither_cnt_reg + 1'b1;
              end
            end else begin
              dither_cnt_next = '0;
            end
            last_dir_next = step_dir;
            locked_next   = (dither_cnt_next >= DITH_W'(LOCK_DITHER));
          end
        end
        ST_STEP: begin
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_W'(HOLDOFF - 1);
          acc_clr       = 1'b1;
        end
        ST_HOLD: begin
          acc_clr = 1'b1;
          if (hold_cnt_reg != '0) begin
            hold_cnt_next = hold_cnt_reg - 1'b1;
          end else begin
            state_next = ST_TRACK;
          end
        end
        default: begin
          state_next = ST_IDLE;
          acc_clr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      hold_cnt_reg   <= '0;
      dither_cnt_reg <= '0;
      last_dir_reg   <= DIR_NONE;
      inc_reg        <= 1'b0;
      dec_reg        <= 1'b0;
      phase_reg      <= '0;
      locked_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      dither_cnt_reg <= dither_cnt_next;
      last_dir_reg   <= last_dir_next;
      inc_reg        <= inc_next;
      dec_reg        <= dec_next;
      phase_reg      <= phase_next;
      locked_reg     <= locked_next;
    end
  end

  assign inc       = inc_reg;
  assign dec       = dec_reg;
  assign phase_sel = phase_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Bench for cdr_loop_filter: directed scenarios plus random votes, checked every cycle
// against an edge-level reference model built from the step/hold-off/lock rules.
module tb_cdr_loop_filter;
  import cdr_pkg::*;

  localparam int ACC_W       = 6;
  localparam int THRESH      = 16;
  localparam int HOLDOFF     = 4;
  localparam int LOCK_DITHER = 4;
  localparam int ACC_LIM     = (1 << (ACC_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst, en, up, dn;
  logic inc, dec, locked;
  logic [PHASE_W-1:0] phase_sel;

  always #5 clk = ~clk;

  cdr_loop_filter #(
    .ACC_W       (ACC_W),
    .THRESH      (THRESH),
    .HOLDOFF     (HOLDOFF),
    .LOCK_DITHER (LOCK_DITHER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .dn        (dn),
    .inc       (inc),
    .dec       (dec),
    .phase_sel (phase_sel),
    .locked    (locked)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: running vote sum, number of upcoming edges whose votes are
  // ignored, the pulse currently presented, the rotator phase and the step history.
  int m_acc, m_ign, m_pulse, m_phase, m_locked;
  bit m_active;
  int hist[$];

  function automatic int reversal_tail();
    int n = 0;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] != hist[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ign = 0; m_pulse = 0; m_phase = 0; m_locked = 0; m_active = 0;
    hist.delete();
  endtask

  task automatic model_edge(input bit e, input bit u, input bit d);
    int v;
    v = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    m_phase = (m_phase + m_pulse + 8) % 8;
    m_pulse = 0;
    if (!e) begin
      m_active = 0; m_acc = 0; m_ign = 0; m_locked = 0;
      hist.delete();
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_ign > 0) begin
      m_ign--;
    end else begin
      m_acc += v;
      if (m_acc > ACC_LIM) m_acc = ACC_LIM;
      if (m_acc < -ACC_LIM) m_acc = -ACC_LIM;
      if (m_acc >= THRESH || m_acc <= -THRESH) begin
        m_pulse = (m_acc > 0) ? 1 : -1;
        m_acc = 0;
        m_ign = 1 + HOLDOFF;   // the STEP edge plus HOLDOFF hold edges
        hist.push_back(m_pulse);
        m_locked = (reversal_tail() >= LOCK_DITHER) ? 1 : 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("inc", {31'd0, inc}, (m_pulse == 1) ? 32'd1 : 32'd0);
    check("dec", {31'd0, dec}, (m_pulse == -1) ? 32'd1 : 32'd0);
    check("phase_sel", {29'd0, phase_sel}, 32'(m_phase));
    check("locked", {31'd0, locked}, 32'(m_locked));
    check("inc_dec_excl", {31'd0, inc & dec}, 32'd0);
  endtask

  task automatic cyc(input bit e, input bit u, input bit d);
    en = e; up = u; dn = d;
    @(posedge clk);
    model_edge(e, u, d);
    #1;
    check_all();
    if (m_pulse != 0)
      $display("step %s phase_sel=%0d locked=%0d t=%0t",
               (m_pulse > 0) ? "inc" : "dec", phase_sel, locked, $time);
  endtask

  task automatic wait_pulse(input bit u, input bit d, input int lim, output int n);
    bit found = 0;
    n = 0;
    while (n < lim && !found) begin
      cyc(1'b1, u, d);
      n++;
      if (inc || dec) found = 1;
    end
    check("pulse_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n, cnt, ph;
    bit u, d, e;
    rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0;
    model_reset();
    #12;
    check("reset_inc", {31'd0, inc}, 32'd0);
    check("reset_dec", {31'd0, dec}, 32'd0);
    check("reset_phase", {29'd0, phase_sel}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Step-up latency and step spacing
    cyc(1'b1, 1'b1, 1'b0);
    wait_pulse(1'b1, 1'b0, 100, n);
    check("t2_latency", 32'(n), 32'(THRESH));
    cyc(1'b1, 1'b1, 1'b0);
    check("t2_phase", {29'd0, phase_sel}, 32'd1);
    wait_pulse(1'b1, 1'b0, 100, n);
    check("t2_spacing", 32'(n + 1), 32'(1 + HOLDOFF + THRESH));

    // Wrap: eight steps up, then one down
    for (int k = 0; k < 6; k++) wait_pulse(1'b1, 1'b0, 100, n);
    cyc(1'b1, 1'b0, 1'b0);
    check("t3_wrap_up", {29'd0, phase_sel}, 32'd0);
    wait_pulse(1'b0, 1'b1, 100, n);
    cyc(1'b1, 1'b0, 1'b1);
    check("t3_wrap_dn", {29'd0, phase_sel}, 32'd7);
    check("t3_dec_single", {31'd0, dec}, 32'd0);

    // Asynchronous reset while in HOLD, checked before any clock edge
    cyc(1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_inc", {31'd0, inc}, 32'd0);
    check("t1_async_dec", {31'd0, dec}, 32'd0);
    check("t1_async_phase", {29'd0, phase_sel}, 32'd0);
    check("t1_async_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Null votes produce no steps
    cnt = 0;
    for (int i = 0; i < 100; i++) begin cyc(1'b1, 1'b1, 1'b1); cnt += int'(inc | dec); end
    for (int i = 0; i < 100; i++) begin cyc(1'b1, 1'b0, 1'b0); cnt += int'(inc | dec); end
    check("t4_no_pulses", 32'(cnt), 32'd0);

    // Lock after four reversals, lost on a repeated direction
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_pulse(k % 2 == 0, k % 2 == 1, 100, n);
      check("t5_lock_progress", {31'd0, locked}, (k == 4) ? 32'd1 : 32'd0);
    end
    wait_pulse(1'b1, 1'b0, 100, n);
    check("t5_lock_loss", {31'd0, locked}, 32'd0);

    // Disable during STEP
    wait_pulse(1'b0, 1'b1, 100, n);
    wait_pulse(1'b1, 1'b0, 100, n);
    ph = int'(phase_sel);
    cyc(1'b0, 1'b1, 1'b0);
    check("t6_pulse_done", {31'd0, inc}, 32'd0);
    check("t6_phase_counted", {29'd0, phase_sel}, 32'((ph + 1) % 8));
    check("t6_unlocked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    check("t6_phase_held", {29'd0, phase_sel}, 32'((ph + 1) % 8));
    cyc(1'b1, 1'b1, 1'b0);
    wait_pulse(1'b1, 1'b0, 100, n);
    check("t6_reenable_latency", 32'(n), 32'(THRESH));

    // Random votes with occasional disable and reset
    for (int i = 0; i < 4000; i++) begin
      int seg;
      seg = (i / 60) % 3;
      e = ($urandom_range(0, 99) != 0);
      u = ($urandom_range(0, 9) < ((seg == 0) ? 7 : 3));
      d = ($urandom_range(0, 9) < ((seg == 1) ? 7 : 3));
      if (seg == 2 && (i % 7) < 4) begin
        u = (i % 120) < 100;
        d = !u;
      end
      cyc(e, u, d);
      if (i % 1000 == 999) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
